// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared fetch-stage types, widths and build configuration.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Build configuration macros (defined here when not supplied on the command line):
//   PC_RESET_ADDRESS     first fetch address after reset (default 32'hBFC0_0000)
//   FETCH_ADEL_CHECK_EN  when defined, misaligned redirect targets are not fetched;
//                        a single address-error entry is queued instead.
`ifndef PC_RESET_ADDRESS
`define PC_RESET_ADDRESS 32'hBFC0_0000
`endif

package fetch_prefetch_unit_pkg;

    localparam int ADDR_W = 32;
    localparam int INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP_IR = '0;

    // One prefetch queue entry: address-error flag, fetch PC and instruction word.
    typedef struct packed {
        logic              adel;
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] ir;
    } fetch_entry_t;

    // Sequential successor of a fetch address; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; stores whole fetch entries.
// Latency: a push is visible at head_dat/count on the following cycle.
// Backpressure: none internally; the writer must respect count (push into full is an error).
//
// Ports: clk, rst (sync, active-high), push/push_dat, pop, flush (clears all entries,
// overrides push), head_dat (oldest entry), count (entries held).
module fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_pop;

    // Popping an empty queue is ignored so the reader may hold pop high.
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                assert (count != CNTW'(DEPTH) || do_pop);
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CNTW'(push) - CNTW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with prefetch queue, credit-limited multiple outstanding reads and redirects.
// Latency: read response on cycle N is presented to ID on cycle N+1; all outputs are registered.
// Backpressure: ID stalls via out_ready; issue stops when queue+in-flight reach FIFO_DEPTH.
//
// Ports: clk, rst (sync, active-high); redirects int_valid/int_enter, bj_valid/bj_target,
// eret_valid/epc (priority in that order); ID side out_valid/out_ready/out_pc/out_ir/
// out_pc_plus_4/out_adel; memory side m_araddr/m_arvalid/m_arready, m_rdata/m_rvalid.
// Optional feature macro: FETCH_ADEL_CHECK_EN (misaligned-target address error entry).
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int                FIFO_DEPTH      = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = `PC_RESET_ADDRESS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_valid,
    input  logic [ADDR_W-1:0] int_enter,
    input  logic              bj_valid,
    input  logic [ADDR_W-1:0] bj_target,
    input  logic              eret_valid,
    input  logic [ADDR_W-1:0] epc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INSN_W-1:0] out_ir,
    output logic [ADDR_W-1:0] out_pc_plus_4,
    output logic              out_adel,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [INSN_W-1:0] m_rdata,
    input  logic              m_rvalid
);

    localparam int CW  = $clog2(MAX_OUTSTANDING + 2);
    localparam int QCW = $clog2(FIFO_DEPTH) + 1;

`ifdef FETCH_ADEL_CHECK_EN
    localparam bit ADEL_EN = 1'b1;
`else
    localparam bit ADEL_EN = 1'b0;
`endif

    // Registered state
    logic [ADDR_W-1:0] fetch_pc;     // next address to request
    logic [ADDR_W-1:0] rsp_pc;       // PC belonging to the next response that is kept
    logic              ar_stale;     // pending AR was issued before a redirect
    logic              stall;        // fetch halted after a misaligned target
    logic              adel_push;    // queue the address-error entry this cycle
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;

    // Queue interface
    logic [QCW-1:0]    q_count;
    logic              q_push;
    logic              q_pop;
    fetch_entry_t      q_push_dat;
    fetch_entry_t      q_head;

    // Combinational next-state
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              misaligned;
    logic              accept;
    logic              ar_hold;
    logic              drop;
    logic              rsp_push;
    logic              can_issue;
    logic [ADDR_W-1:0] fetch_pc_n;
    logic [ADDR_W-1:0] rsp_pc_n;
    logic [ADDR_W-1:0] ar_addr_n;
    logic              ar_vld_n;
    logic              ar_stale_n;
    logic              stall_n;
    logic              adel_push_n;
    logic [CW-1:0]     outstanding_n;
    logic [CW-1:0]     discard_n;
    logic [QCW-1:0]    q_count_n;

    always_comb begin
        redirect      = int_valid || bj_valid || eret_valid;
        target        = epc;
        if (int_valid) begin
            target = int_enter;
        end else if (bj_valid) begin
            target = bj_target;
        end
        misaligned    = ADEL_EN && (target[1:0] != 2'b00);

        accept        = m_arvalid && m_arready;
        ar_hold       = m_arvalid && !m_arready;
        drop          = m_rvalid && (discard != '0);
        rsp_push      = m_rvalid && !drop;
        q_pop         = out_valid && out_ready;
        q_push        = rsp_push || adel_push;

        // While stalled, fetch_pc still holds the misaligned target.
        q_push_dat    = '{adel: 1'b0, pc: rsp_pc, ir: m_rdata};
        if (adel_push) begin
            q_push_dat = '{adel: 1'b1, pc: fetch_pc, ir: NOP_IR};
        end

        outstanding_n = outstanding + CW'(accept) - CW'(m_rvalid);

        // Everything in flight after this cycle, plus an AR that is still waiting,
        // belongs to the old stream once a redirect is taken.
        discard_n     = discard - CW'(drop);
        fetch_pc_n    = fetch_pc;
        if (accept && !ar_stale) begin
            fetch_pc_n = pc_next(fetch_pc);
        end
        rsp_pc_n      = rsp_push ? pc_next(rsp_pc) : rsp_pc;
        ar_stale_n    = accept ? 1'b0 : ar_stale;
        stall_n       = stall;
        adel_push_n   = 1'b0;
        q_count_n     = q_count + QCW'(q_push) - QCW'(q_pop);

        if (redirect) begin
            discard_n   = outstanding_n + CW'(ar_hold);
            fetch_pc_n  = target;
            rsp_pc_n    = target;
            ar_stale_n  = ar_hold;
            stall_n     = misaligned;
            adel_push_n = misaligned;
            q_count_n   = '0;
        end

        // Credit check on the state the next cycle will see, so back-to-back issue works.
        can_issue     = !stall_n
                        && (int'(q_count_n) + int'(outstanding_n) < FIFO_DEPTH)
                        && (int'(outstanding_n) < MAX_OUTSTANDING);

        // A raised request keeps its address until accepted, even across redirects.
        ar_vld_n      = ar_hold || can_issue;
        ar_addr_n     = ar_hold ? m_araddr : fetch_pc_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            m_araddr    <= RESET_PC;
            m_arvalid   <= 1'b0;
            ar_stale    <= 1'b0;
            stall       <= 1'b0;
            adel_push   <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            fetch_pc    <= fetch_pc_n;
            rsp_pc      <= rsp_pc_n;
            m_araddr    <= ar_addr_n;
            m_arvalid   <= ar_vld_n;
            ar_stale    <= ar_stale_n;
            stall       <= stall_n;
            adel_push   <= adel_push_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
        end
    end

    // Flush wins over a same-cycle push; a same-cycle pop still delivers the head.
    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat (q_push_dat),
        .pop      (q_pop),
        .flush    (redirect),
        .head_dat (q_head),
        .count    (q_count)
    );

    assign out_valid     = (q_count != '0);
    assign out_pc        = q_head.pc;
    assign out_ir        = q_head.ir;
    assign out_pc_plus_4 = pc_next(q_head.pc);
    assign out_adel      = ADEL_EN && q_head.adel;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a 1-cycle-latency in-order memory model.
// Latency: n/a.
// Backpressure: memory responses can be held off (mem_hold), AR acceptance via m_arready.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_valid, bj_valid, eret_valid;
    logic [31:0] int_enter, bj_target, epc;
    logic        out_valid, out_ready, out_adel;
    logic [31:0] out_pc, out_ir, out_pc_plus_4;
    logic [31:0] m_araddr, m_rdata;
    logic        m_arvalid, m_arready, m_rvalid;
    logic        mem_hold;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    logic [31:0] acc_log[$];
    logic [31:0] mem_q[$];
    logic [31:0] d_pc[$];
    logic [31:0] d_ir[$];
    logic [31:0] d_pc4[$];
    logic        d_adel[$];
    int          d_cyc[$];

    always #5 clk = ~clk;

    fetch_prefetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .int_valid     (int_valid),
        .int_enter     (int_enter),
        .bj_valid      (bj_valid),
        .bj_target     (bj_target),
        .eret_valid    (eret_valid),
        .epc           (epc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_ir        (out_ir),
        .out_pc_plus_4 (out_pc_plus_4),
        .out_adel      (out_adel),
        .m_araddr      (m_araddr),
        .m_arvalid     (m_arvalid),
        .m_arready     (m_arready),
        .m_rdata       (m_rdata),
        .m_rvalid      (m_rvalid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Delivered word idx must carry exp_pc, its memory word and exp_pc+4.
    task automatic check_del(input string tag, input int idx, input logic [31:0] exp_pc);
        if (d_pc.size() > idx) begin
            chk($sformatf("%s_pc", tag), d_pc[idx], exp_pc);
            chk($sformatf("%s_ir", tag), d_ir[idx], mem_word(exp_pc));
            chk($sformatf("%s_pc4", tag), d_pc4[idx], exp_pc + 32'd4);
        end else begin
            chk($sformatf("%s_count", tag), 32'(d_pc.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_acc(input string tag, input int idx, input logic [31:0] exp_addr);
        if (acc_log.size() > idx) begin
            chk(tag, acc_log[idx], exp_addr);
        end else begin
            chk($sformatf("%s_count", tag), 32'(acc_log.size()), 32'(idx + 1));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        acc_log.delete();
        d_pc.delete();
        d_ir.delete();
        d_pc4.delete();
        d_adel.delete();
        d_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        clear_obs();
        rst = 1'b0;
    endtask

    // Observer: accepted reads and words handed to ID.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                if (out_valid && out_ready) begin
                    d_pc.push_back(out_pc);
                    d_ir.push_back(out_ir);
                    d_pc4.push_back(out_pc_plus_4);
                    d_adel.push_back(out_adel);
                    d_cyc.push_back(cyc);
                end
                if (m_arvalid && m_arready) begin
                    acc_log.push_back(m_araddr);
                end
            end
        end
    end

    // Memory: answers each accepted read on the following cycle, in order.
    initial begin
        m_rvalid = 1'b0;
        m_rdata  = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mem_q.delete();
            end else if (m_arvalid && m_arready) begin
                mem_q.push_back(m_araddr);
            end
            @(negedge clk);
            if (!mem_hold && mem_q.size() > 0) begin
                m_rvalid = 1'b1;
                m_rdata  = mem_word(mem_q.pop_front());
            end else begin
                m_rvalid = 1'b0;
                m_rdata  = '0;
            end
        end
    end

    initial begin
        int n_bad;
        rst        = 1'b1;
        int_valid  = 1'b0;
        bj_valid   = 1'b0;
        eret_valid = 1'b0;
        int_enter  = '0;
        bj_target  = '0;
        epc        = '0;
        out_ready  = 1'b1;
        m_arready  = 1'b1;
        mem_hold   = 1'b0;

        // Reset and sequential streaming at one word per cycle
        step(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_arvalid", 32'(m_arvalid), 32'd0);
        clear_obs();
        rst = 1'b0;
        step(1);
        chk("first_arvalid", 32'(m_arvalid), 32'd1);
        chk("first_araddr", m_araddr, 32'hBFC0_0000);
        step(11);
        for (int i = 0; i < 5; i++) begin
            check_del($sformatf("seq%0d", i), i, 32'hBFC0_0000 + 32'(4 * i));
        end
        if (d_cyc.size() >= 5) begin
            chk("seq_rate", 32'(d_cyc[4] - d_cyc[0]), 32'd4);
            chk("seq_adel", 32'(d_adel[0]), 32'd0);
        end else begin
            chk("seq_rate_count", 32'(d_cyc.size()), 32'd5);
        end

        // ID stalled from reset: exactly FIFO_DEPTH reads, then issue stops
        out_ready = 1'b0;
        do_reset();
        step(20);
        chk("stall_accepts", 32'(acc_log.size()), 32'd4);
        chk("stall_arvalid", 32'(m_arvalid), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_head_pc", out_pc, 32'hBFC0_0000);
        out_ready = 1'b1;
        step(8);
        for (int i = 0; i < 5; i++) begin
            check_del($sformatf("drain%0d", i), i, 32'hBFC0_0000 + 32'(4 * i));
        end

        // Branch with MAX_OUTSTANDING reads in flight; both responses dropped
        mem_hold = 1'b1;
        do_reset();
        step(6);
        chk("bj_outstanding", 32'(acc_log.size()), 32'd2);
        chk("bj_arvalid_capped", 32'(m_arvalid), 32'd0);
        bj_valid  = 1'b1;
        bj_target = 32'h8000_1000;
        step(1);
        bj_valid = 1'b0;
        mem_hold = 1'b0;
        clear_obs();
        step(10);
        check_acc("bj_first_ar", 0, 32'h8000_1000);
        check_del("bj0", 0, 32'h8000_1000);
        check_del("bj1", 1, 32'h8000_1004);

        // Simultaneous redirects from a full, idle queue: interrupt wins
        out_ready = 1'b0;
        step(12);
        chk("prio_idle_arvalid", 32'(m_arvalid), 32'd0);
        chk("prio_full_valid", 32'(out_valid), 32'd1);
        int_valid  = 1'b1;
        int_enter  = 32'h8000_0180;
        bj_valid   = 1'b1;
        bj_target  = 32'h8000_2000;
        eret_valid = 1'b1;
        epc        = 32'h8000_3000;
        step(1);
        int_valid  = 1'b0;
        bj_valid   = 1'b0;
        eret_valid = 1'b0;
        clear_obs();
        out_ready = 1'b1;
        step(8);
        check_acc("prio_first_ar", 0, 32'h8000_0180);
        check_del("prio0", 0, 32'h8000_0180);
        check_del("prio1", 1, 32'h8000_0184);

        // Redirect while an AR is stalled by m_arready: address holds, its data is dropped
        m_arready = 1'b0;
        do_reset();
        step(1);
        chk("hold_arvalid", 32'(m_arvalid), 32'd1);
        chk("hold_araddr0", m_araddr, 32'hBFC0_0000);
        eret_valid = 1'b1;
        epc        = 32'h8000_4000;
        step(1);
        eret_valid = 1'b0;
        chk("hold_araddr1", m_araddr, 32'hBFC0_0000);
        chk("hold_arvalid1", 32'(m_arvalid), 32'd1);
        step(1);
        chk("hold_araddr2", m_araddr, 32'hBFC0_0000);
        m_arready = 1'b1;
        step(10);
        check_acc("hold_ar0", 0, 32'hBFC0_0000);
        check_acc("hold_ar1", 1, 32'h8000_4000);
        check_del("hold0", 0, 32'h8000_4000);
        check_del("hold1", 1, 32'h8000_4004);

        // Address wrap at the top of the address space
        bj_valid  = 1'b1;
        bj_target = 32'hFFFF_FFFC;
        step(1);
        bj_valid = 1'b0;
        clear_obs();
        step(8);
        check_del("wrap0", 0, 32'hFFFF_FFFC);
        check_del("wrap1", 1, 32'h0000_0000);

`ifdef FETCH_ADEL_CHECK_EN
        // Misaligned return address: one error entry, no memory read, fetch stalls
        eret_valid = 1'b1;
        epc        = 32'h8000_0002;
        step(1);
        eret_valid = 1'b0;
        clear_obs();
        step(10);
        chk("adel_count", 32'(d_pc.size()), 32'd1);
        if (d_pc.size() > 0) begin
            chk("adel_pc", d_pc[0], 32'h8000_0002);
            chk("adel_ir", d_ir[0], 32'h0000_0000);
            chk("adel_flag", 32'(d_adel[0]), 32'd1);
        end
        n_bad = 0;
        foreach (acc_log[i]) begin
            if (acc_log[i] == 32'h8000_0002) n_bad++;
        end
        chk("adel_no_ar", 32'(n_bad), 32'd0);
        chk("adel_stalled", 32'(m_arvalid), 32'd0);
`else
        // Without the check, address-error flag never rises
        n_bad = 0;
        foreach (d_adel[i]) begin
            if (d_adel[i]) n_bad++;
        end
        chk("no_adel", 32'(n_bad), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
